multi_channel_fifo_in: RTL and testbench

- Parametrised N-channel input buffer for the vip_top front end.
- Replaces the fixed 3/8 separate fifo_in_data_x ports with one flattened NUM_CH*DWIDTH bus sharing a single wrreq/full handshake.
- Tracks the raster position (column, row, image) of the head word so the conv pipeline receives end-of-line, end-of-frame and end-of-set flags with each pixel vector.
- Sits between the stimulus or upstream stage and the first conv layer.

---
 rtl/vgg_stream_pkg.sv | 24 ++
 rtl/raster_pos_counter.sv | 55 +++++
 rtl/multi_channel_fifo_in.sv | 108 ++++++++++
 tb/tb_multi_channel_fifo_in.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vgg_stream_pkg.sv
// Shared types and helpers for the vgg_stream front-end blocks.
// Default channel geometry, width helper and flattened-bus slicing.
package vgg_stream_pkg;

   localparam int DEF_DWIDTH = 32;
   localparam int DEF_NUM_CH = 8;

   typedef struct packed {
      logic eol;
      logic eof;
      logic eos;
   } raster_flags_t;

   // $clog2 with a floor of 1 so a limit of 1 still gets a real register bit
   function automatic int CLOG2(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

   // Base bit offset of channel c inside a flattened NUM_CH*width bus
   function automatic int unsigned chan_slice(input int unsigned c, input int unsigned width);
      return c * width;
   endfunction

endpackage

// File: rtl/raster_pos_counter.sv
// Column/row/image position counter; advances once per consumed pixel and
// reports whether the current position ends a line, image or set.
module raster_pos_counter
   import vgg_stream_pkg::*;
#(
   parameter int WIDTH   = 224,
   parameter int HEIGHT  = 224,
   parameter int NUM_IMG = 1
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          advance,
   output raster_flags_t flags
);

   localparam int CW = CLOG2(WIDTH);
   localparam int RW = CLOG2(HEIGHT);
   localparam int IW = CLOG2(NUM_IMG);

   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
   localparam logic [IW-1:0] IMG_LAST = IW'(NUM_IMG - 1);

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [IW-1:0] img;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         col <= '0;
         row <= '0;
         img <= '0;
      end else if (advance) begin
         if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) begin
               row <= '0;
               img <= (img == IMG_LAST) ? '0 : img + IW'(1);
            end else begin
               row <= row + RW'(1);
            end
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   always_comb begin
      flags     = '0;
      flags.eol = (col == COL_LAST);
      flags.eof = flags.eol & (row == ROW_LAST);
      flags.eos = flags.eof & (img == IMG_LAST);
   end

endmodule

// File: rtl/multi_channel_fifo_in.sv
// N-channel show-ahead input FIFO with raster end-of-line/frame/set flags.
// Optional DROP_CNT_EN adds a saturating count of writes rejected while full.
module multi_channel_fifo_in
   import vgg_stream_pkg::*;
#(
   parameter int DWIDTH    = DEF_DWIDTH,
   parameter int NUM_CH    = DEF_NUM_CH,
   parameter int DEPTH     = 16,
   parameter int WIDTH     = 224,
   parameter int HEIGHT    = 224,
   parameter int NUM_IMG   = 1,
   parameter int AF_MARGIN = 2
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic [NUM_CH*DWIDTH-1:0]   wr_data,
   input  logic                       wrreq,
   output logic                       full,
   output logic                       almost_full,
   output logic [NUM_CH*DWIDTH-1:0]   rd_data,
   input  logic                       rdreq,
   output logic                       empty,
   output logic                       eol,
   output logic                       eof,
   output logic                       eos,
   output logic [$clog2(DEPTH):0]     count,
   output logic [15:0]                drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CNTW = AW + 1;
   localparam int BW = NUM_CH * DWIDTH;

   logic [BW-1:0]   mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CNTW-1:0] count_nxt;
   logic            wr_en;
   logic            rd_en;
   raster_flags_t   pos;

   // Full is sampled before the pop, so a full-state write+read is read only
   assign wr_en = wrreq & ~full;
   assign rd_en = rdreq & ~empty;

   always_comb begin
      count_nxt = count;
      if (wr_en && !rd_en)
         count_nxt = count + CNTW'(1);
      else if (rd_en && !wr_en)
         count_nxt = count - CNTW'(1);
   end

   always_ff @(posedge clock) begin
      if (wr_en)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         full        <= 1'b0;
         empty       <= 1'b1;
         almost_full <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_en)
            rd_ptr <= rd_ptr + AW'(1);
         count       <= count_nxt;
         full        <= (count_nxt == CNTW'(DEPTH));
         empty       <= (count_nxt == '0);
         almost_full <= (count_nxt >= CNTW'(DEPTH - AF_MARGIN));
      end
   end

   // Gating on empty also forces zero during reset and hides stale memory
   assign rd_data = empty ? '0 : mem[rd_ptr];

   raster_pos_counter #(
      .WIDTH   (WIDTH),
      .HEIGHT  (HEIGHT),
      .NUM_IMG (NUM_IMG)
   ) u_pos (
      .clock   (clock),
      .resetn  (resetn),
      .advance (rd_en),
      .flags   (pos)
   );

   assign eol = ~empty & pos.eol;
   assign eof = ~empty & pos.eof;
   assign eos = ~empty & pos.eos;

`ifdef DROP_CNT_EN
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         drop_cnt <= '0;
      else if (wrreq && full && drop_cnt != 16'hFFFF)
         drop_cnt <= drop_cnt + 16'd1;
   end
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_channel_fifo_in.sv
// Randomised self-checking bench for multi_channel_fifo_in against a queue model.
module tb_multi_channel_fifo_in;
   import vgg_stream_pkg::*;

   localparam int DW  = 32;
   localparam int NCH = 3;
   localparam int DEP = 16;
   localparam int W   = 4;
   localparam int H   = 2;
   localparam int NI  = 2;
   localparam int AFM = 2;
   localparam int BW  = NCH * DW;

   logic          clock = 1'b0;
   logic          resetn = 1'b0;
   logic [BW-1:0] wr_data = '0;
   logic          wrreq = 1'b0;
   logic          rdreq = 1'b0;
   logic          full, almost_full, empty, eol, eof, eos;
   logic [BW-1:0] rd_data;
   logic [4:0]    count;
   logic [15:0]   drop_cnt;

   int checks = 0;
   int errors = 0;

   logic [BW-1:0] m_q[$];
   int            m_pops = 0;
   int            m_drops = 0;

   always #5 clock = ~clock;

   multi_channel_fifo_in #(
      .DWIDTH    (DW),
      .NUM_CH    (NCH),
      .DEPTH     (DEP),
      .WIDTH     (W),
      .HEIGHT    (H),
      .NUM_IMG   (NI),
      .AF_MARGIN (AFM)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .wr_data     (wr_data),
      .wrreq       (wrreq),
      .full        (full),
      .almost_full (almost_full),
      .rd_data     (rd_data),
      .rdreq       (rdreq),
      .empty       (empty),
      .eol         (eol),
      .eof         (eof),
      .eos         (eos),
      .count       (count),
      .drop_cnt    (drop_cnt)
   );

   // Position of the head word = number of pixels consumed since reset
   function automatic logic [5:0] exp_flags();
      int  n = m_q.size();
      logic e_eol, e_eof, e_eos;
      e_eol = (n > 0) && ((m_pops % W) == W - 1);
      e_eof = e_eol && (((m_pops / W) % H) == H - 1);
      e_eos = e_eof && (((m_pops / (W * H)) % NI) == NI - 1);
      return {n == DEP, n == 0, n >= DEP - AFM, e_eol, e_eof, e_eos};
   endfunction

   function automatic logic [BW-1:0] exp_rd();
      return (m_q.size() > 0) ? m_q[0] : '0;
   endfunction

   function automatic logic [4:0] exp_count();
      return 5'(m_q.size());
   endfunction

   function automatic logic [15:0] exp_drop();
`ifdef DROP_CNT_EN
      return 16'(m_drops);
`else
      return 16'h0;
`endif
   endfunction

   function automatic logic [BW-1:0] rand_word();
      logic [BW-1:0] v;
      for (int c = 0; c < NCH; c++)
         v[c*DW +: DW] = $urandom();
      return v;
   endfunction

   function automatic logic [5:0] dut_flags();
      return {full, empty, almost_full, eol, eof, eos};
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_pops = 0;
      m_drops = 0;
   endtask

   // Drive one cycle, advance the model on the edge, leave time at edge+1
   task automatic step(input logic wr, input logic [BW-1:0] d, input logic rd);
      int  n;
      logic rd_ok, wr_ok;
      wrreq = wr;
      wr_data = d;
      rdreq = rd;
      @(posedge clock);
      n = m_q.size();
      wr_ok = wr && (n < DEP);
      rd_ok = rd && (n > 0);
      if (wr && n == DEP && m_drops < 65535)
         m_drops++;
      if (rd_ok) begin
         void'(m_q.pop_front());
         m_pops++;
      end
      if (wr_ok)
         m_q.push_back(d);
      #1;
      wrreq = 1'b0;
      rdreq = 1'b0;
   endtask

   task automatic async_reset_pulse();
      #2 resetn = 1'b0;
      #1;
      model_reset();
      checks++;
      if (count !== 5'd0 || dut_flags() !== 6'b010000) begin
         errors++;
         $display("FAIL async_reset count=%0d flags=%b need count=0 flags=010000", count, dut_flags());
      end
      checks++;
      if (rd_data !== '0) begin
         errors++;
         $display("FAIL async_reset_rd_data got %h need 0", rd_data);
      end
      #1 resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      model_reset();
      checks++;
      if (dut_flags() !== exp_flags() || count !== exp_count()) begin
         errors++;
         $display("FAIL reset_state flags=%b count=%0d need flags=%b count=%0d", dut_flags(), count, exp_flags(), exp_count());
      end
      checks++;
      if (rd_data !== '0 || drop_cnt !== 16'h0) begin
         errors++;
         $display("FAIL reset_data rd_data=%h drop_cnt=%0d need 0/0", rd_data, drop_cnt);
      end
      #2 resetn = 1'b1;
   endtask

   task automatic test_fill();
      logic [BW-1:0] w;
      for (int i = 0; i < DEP; i++) begin
         w = rand_word();
         w[DW-1:0] = i;
         step(1'b1, w, 1'b0);
         checks++;
         if (count !== exp_count() || dut_flags() !== exp_flags()) begin
            errors++;
            $display("FAIL fill[%0d] count=%0d flags=%b need count=%0d flags=%b", i, count, dut_flags(), exp_count(), exp_flags());
         end
      end
      step(1'b1, rand_word(), 1'b0);
      checks++;
      if (count !== 5'd16 || full !== 1'b1 || drop_cnt !== exp_drop()) begin
         errors++;
         $display("FAIL fill_overflow count=%0d full=%b drop=%0d need 16/1/%0d", count, full, drop_cnt, exp_drop());
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < DEP; i++) begin
         checks++;
         if (rd_data[DW-1:0] !== DW'(i) || rd_data !== exp_rd()) begin
            errors++;
            $display("FAIL drain_order[%0d] got %h need %h", i, rd_data, exp_rd());
         end
         checks++;
         if (dut_flags() !== exp_flags()) begin
            errors++;
            $display("FAIL drain_flags[%0d] got %b need %b", i, dut_flags(), exp_flags());
         end
         step(1'b0, '0, 1'b1);
      end
      step(1'b0, '0, 1'b1);
      checks++;
      if (count !== 5'd0 || dut_flags() !== exp_flags()) begin
         errors++;
         $display("FAIL drain_empty_read count=%0d flags=%b need 0/%b", count, dut_flags(), exp_flags());
      end
      step(1'b1, rand_word(), 1'b0);
      checks++;
      if (dut_flags() !== exp_flags() || eol !== 1'b0) begin
         errors++;
         $display("FAIL raster_wrap flags=%b need %b", dut_flags(), exp_flags());
      end
      step(1'b0, '0, 1'b1);
   endtask

   task automatic test_simultaneous();
      repeat (5) step(1'b1, rand_word(), 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, rand_word(), 1'b1);
         checks++;
         if (count !== 5'd5 || rd_data !== exp_rd()) begin
            errors++;
            $display("FAIL simul_mid[%0d] count=%0d rd=%h need 5/%h", i, count, rd_data, exp_rd());
         end
      end
      while (m_q.size() < DEP) step(1'b1, rand_word(), 1'b0);
      step(1'b1, rand_word(), 1'b1);
      checks++;
      if (count !== 5'd15 || drop_cnt !== exp_drop() || rd_data !== exp_rd()) begin
         errors++;
         $display("FAIL simul_full count=%0d drop=%0d rd=%h need 15/%0d/%h", count, drop_cnt, rd_data, exp_drop(), exp_rd());
      end
      while (m_q.size() > 0) step(1'b0, '0, 1'b1);
      step(1'b1, rand_word(), 1'b1);
      checks++;
      if (count !== 5'd1 || rd_data !== exp_rd() || dut_flags() !== exp_flags()) begin
         errors++;
         $display("FAIL simul_empty count=%0d rd=%h flags=%b need 1/%h/%b", count, rd_data, dut_flags(), exp_rd(), exp_flags());
      end
   endtask

   task automatic test_channel_map();
      logic [BW-1:0] w;
      while (m_q.size() > 0) step(1'b0, '0, 1'b1);
      w = {32'hC, 32'hB, 32'hA};
      step(1'b1, w, 1'b0);
      checks++;
      if (rd_data[chan_slice(0, DW) +: DW] !== 32'hA || rd_data[chan_slice(1, DW) +: DW] !== 32'hB ||
          rd_data[chan_slice(2, DW) +: DW] !== 32'hC) begin
         errors++;
         $display("FAIL channel_map got %h need 0000000c0000000b0000000a", rd_data);
      end
      step(1'b0, '0, 1'b1);
   endtask

   task automatic test_random();
      logic wr, rd;
      for (int i = 0; i < 400; i++) begin
         wr = ($urandom_range(0, 99) < 55);
         rd = ($urandom_range(0, 99) < 50);
         step(wr, rand_word(), rd);
         checks++;
         if (count !== exp_count() || dut_flags() !== exp_flags()) begin
            errors++;
            $display("FAIL random[%0d] count=%0d flags=%b need %0d/%b", i, count, dut_flags(), exp_count(), exp_flags());
         end
         checks++;
         if (rd_data !== exp_rd() || drop_cnt !== exp_drop()) begin
            errors++;
            $display("FAIL random_data[%0d] rd=%h drop=%0d need %h/%0d", i, rd_data, drop_cnt, exp_rd(), exp_drop());
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [BW-1:0] w;
      async_reset_pulse();
      repeat (9) step(1'b1, rand_word(), 1'b0);
      repeat (2) step(1'b0, '0, 1'b1);
      checks++;
      if (count !== 5'd7 || m_pops != 2) begin
         errors++;
         $display("FAIL reset_mid_setup count=%0d need 7", count);
      end
      async_reset_pulse();
      w = rand_word();
      step(1'b1, w, 1'b0);
      checks++;
      if (rd_data !== w || dut_flags() !== exp_flags() || {eol, eof, eos} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_restart rd=%h flags=%b need %h/%b", rd_data, dut_flags(), w, exp_flags());
      end
      step(1'b0, '0, 1'b1);
      checks++;
      if (count !== 5'd0 || dut_flags() !== exp_flags()) begin
         errors++;
         $display("FAIL reset_mid_drain count=%0d flags=%b need 0/%b", count, dut_flags(), exp_flags());
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_simultaneous();
      test_channel_map();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
